crop_filter_multi: RTL and testbench
====================================

Name: crop_filter_multi

Overview:
Streaming multi-window crop stage, the parametrised successor of crop_filter. For each frame it accepts NUM_CROPS crop origins (Y1,X1), then streams one IN_ROWS x IN_COLS raster-order image. It emits every pixel that falls inside each OUT_ROWS x OUT_COLS window, tagged with the window's crop ID and a per-window TLAST. Sits between the pixel source and the per-crop Gaussian filter, which demultiplexes by TID.

Parameters:
PIXEL_BIT_WIDTH, 16, pixel data width
IN_ROWS, 100, input image rows
IN_COLS, 160, input image columns
OUT_ROWS, 48, crop window rows
OUT_COLS, 48, crop window columns
IMG_ROW_BITWIDTH, 10, row coordinate/counter width
IMG_COL_BITWIDTH, 10, column coordinate/counter width
NUM_CROPS, 4, crop windows per frame (1..16)
CROP_ID_WIDTH, max(1,$clog2(NUM_CROPS)), TID width (derived)

Ports:
clk  in  1  single clock, all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
crop_TDATA  in  IMG_ROW_BITWIDTH+IMG_COL_BITWIDTH  crop origin, packed {Y1,X1}; Y1 in the MSBs
crop_TVALID  in  1  crop origin valid
crop_TREADY  out  1  crop origin accepted when high with TVALID
pixel_in_TDATA  in  PIXEL_BIT_WIDTH  input pixel, raster order
pixel_in_TVALID  in  1  input pixel valid
pixel_in_TREADY  out  1  input pixel accepted when high with TVALID
pixel_out_TDATA  out  PIXEL_BIT_WIDTH  cropped pixel
pixel_out_TID  out  CROP_ID_WIDTH  index of the crop this beat belongs to
pixel_out_TLAST  out  1  last pixel of that crop window
pixel_out_TVALID  out  1  output valid
pixel_out_TREADY  in  1  downstream ready
frame_done  out  1  one-cycle pulse when a frame is fully emitted

Behaviour:
- Reset (reset_n low, takes effect immediately, asynchronous): state=LOAD, crop count=0, row/col=0, pending mask=0.
- Output values during reset: pixel_out_TDATA=0, TID=0, TLAST=0, TVALID=0, pixel_in_TREADY=0, crop_TREADY=1, frame_done=0.
- FSM states: LOAD, STREAM, DRAIN.
- LOAD:
  - crop_TREADY=1, pixel_in_TREADY=0.
  - Each handshake stores the origin into slot crop_cnt, then crop_cnt increments.
  - Clamp on store: Y1 = min(Y1, IN_ROWS-OUT_ROWS); X1 = min(X1, IN_COLS-OUT_COLS).
  - After slot NUM_CROPS-1 is stored -> STREAM.
- STREAM:
  - crop_TREADY=0.
  - pixel_in_TREADY = (mask==0) || (mask has exactly one bit set && pixel_out_TREADY). Full throughput when each pixel hits at most one crop.
  - On accept, at the current (row,col): hit[k] = Y1k<=row<=Y1k+OUT_ROWS-1 && X1k<=col<=X1k+OUT_COLS-1.
  - Register pixel, row, col and hit mask. A zero mask means the pixel is dropped.
  - col wraps at IN_COLS-1 to 0 and row increments.
  - Accepting pixel (IN_ROWS-1, IN_COLS-1) -> DRAIN.
- Emission:
  - pixel_out_TVALID = |mask.
  - TID = index of the lowest set mask bit; TDATA = registered pixel.
  - TLAST=1 iff registered row==Y1+OUT_ROWS-1 && col==X1+OUT_COLS-1 for that crop.
  - Each output handshake clears that mask bit. Overlapping crops emit the same pixel once per crop, ascending TID, one beat per cycle.
  - Latency: a pixel accepted at edge N is first visible after edge N.
  - TDATA, TID and TLAST are held stable while TVALID && !TREADY.
- DRAIN: pixel_in_TREADY=0. When mask==0 -> LOAD, with frame_done=1 for exactly that one cycle. crop_cnt=0, row=col=0.
- Beats per frame: exactly NUM_CROPS*OUT_ROWS*OUT_COLS; per TID, OUT_ROWS*OUT_COLS beats in raster order with exactly one TLAST.
- Simultaneous accept and emit of the last mask bit in the same cycle: the new pixel's mask replaces the old one. No bubble, no loss.
- Reset asserted mid-frame: the partial frame is discarded and the block restarts in LOAD.

Test Plan:
1. NUM_CROPS=1, crop (0,0), pixel value = raster index, TVALID/TREADY held high -> 2304 beats; beat k = (k/48)*160 + k%48; TLAST only on beat 2303 (data 7567); frame_done pulses once.
2. NUM_CROPS=1, crop (99,159) -> clamped to (52,112); first beat 8432, last beat 15999 with TLAST.
3. NUM_CROPS=2, crops (0,0),(0,0) -> 4608 beats; every pixel emitted as TID0 then TID1; pixel_in_TREADY low for exactly 1 cycle per hit pixel.
4. NUM_CROPS=4, crops (37,59),(52,112),(0,0),(10,10), TVALID/TREADY randomised 50% -> per-TID streams match golden files; TDATA/TID/TLAST never change while stalled.
5. reset_n pulsed low after 5000 accepted pixels -> TVALID=0 and crop_TREADY=1 immediately; next frame with crop (0,0) matches test 1.
6. crop_TVALID held high through STREAM -> no extra crop handshakes (crop_TREADY=0); two back-to-back frames each produce the correct count and one frame_done pulse.

Source files
------------

// File: rtl/crop_filter_multi.sv
// crop_filter_multi: streaming multi-window crop.
// Each frame starts by loading NUM_CROPS crop origins {Y1,X1}, clamped so the
// window stays inside the image. Then one IN_ROWS x IN_COLS raster image is
// streamed. Every pixel that lies inside a window is emitted once per window,
// in ascending TID order, with TLAST on that window's bottom-right pixel.
// Ports:
//   clk, reset_n              clock, async active-low reset
//   crop_T*                   crop origin stream, {Y1,X1}, Y1 in the MSBs
//   pixel_in_T*               input pixel stream, raster order
//   pixel_out_T*              cropped pixel stream (TID = crop index)
//   frame_done                one-cycle pulse once a frame is fully emitted
module crop_filter_multi #(
  parameter int PIXEL_BIT_WIDTH  = 16,
  parameter int IN_ROWS          = 100,
  parameter int IN_COLS          = 160,
  parameter int OUT_ROWS         = 48,
  parameter int OUT_COLS         = 48,
  parameter int IMG_ROW_BITWIDTH = 10,
  parameter int IMG_COL_BITWIDTH = 10,
  parameter int NUM_CROPS        = 4,
  parameter int CROP_ID_WIDTH    = (NUM_CROPS > 1) ? $clog2(NUM_CROPS) : 1
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic [IMG_ROW_BITWIDTH+IMG_COL_BITWIDTH-1:0] crop_TDATA,
  input  logic                                      crop_TVALID,
  output logic                                      crop_TREADY,
  input  logic [PIXEL_BIT_WIDTH-1:0]                pixel_in_TDATA,
  input  logic                                      pixel_in_TVALID,
  output logic                                      pixel_in_TREADY,
  output logic [PIXEL_BIT_WIDTH-1:0]                pixel_out_TDATA,
  output logic [CROP_ID_WIDTH-1:0]                  pixel_out_TID,
  output logic                                      pixel_out_TLAST,
  output logic                                      pixel_out_TVALID,
  input  logic                                      pixel_out_TREADY,
  output logic                                      frame_done
);
  localparam int RW  = IMG_ROW_BITWIDTH;
  localparam int CLW = IMG_COL_BITWIDTH;
  localparam int REW = RW + 1;   // window end may need one extra bit
  localparam int CEW = CLW + 1;
  localparam logic [RW-1:0]  Y_MAX = RW'(IN_ROWS - OUT_ROWS);
  localparam logic [CLW-1:0] X_MAX = CLW'(IN_COLS - OUT_COLS);

  typedef enum logic [1:0] {LOAD, STREAM, DRAIN} state_t;

  state_t                     state, state_nxt;
  logic [CROP_ID_WIDTH-1:0]   crop_cnt;
  logic [RW-1:0]              row, reg_row;
  logic [CLW-1:0]             col, reg_col;
  logic [PIXEL_BIT_WIDTH-1:0] pix;
  logic [NUM_CROPS-1:0]       mask, hit, last_vec, low_bit;
  logic [RW-1:0]              y_in;
  logic [CLW-1:0]             x_in;
  logic                       crop_load, pix_acc, emit, onehot;
  logic                       last_row, last_col, last_slot;

  assign y_in      = crop_TDATA[RW+CLW-1:CLW];
  assign x_in      = crop_TDATA[CLW-1:0];
  assign crop_load = crop_TVALID && crop_TREADY;
  assign pix_acc   = pixel_in_TVALID && pixel_in_TREADY;
  assign emit      = pixel_out_TVALID && pixel_out_TREADY;
  assign last_row  = (row == RW'(IN_ROWS - 1));
  assign last_col  = (col == CLW'(IN_COLS - 1));
  assign last_slot = (crop_cnt == CROP_ID_WIDTH'(NUM_CROPS - 1));
  assign onehot    = (mask != '0) && ((mask & (mask - 1'b1)) == '0);

  // Per-crop lane: clamped origin, hit test on the pixel being accepted,
  // last-pixel test on the registered pixel.
  for (genvar k = 0; k < NUM_CROPS; k++) begin : g_crop
    logic [RW-1:0]  y1;
    logic [CLW-1:0] x1;
    logic [REW-1:0] y_end;
    logic [CEW-1:0] x_end;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        y1 <= '0;
        x1 <= '0;
      end else if (crop_load && (crop_cnt == CROP_ID_WIDTH'(k))) begin
        y1 <= (y_in > Y_MAX) ? Y_MAX : y_in;
        x1 <= (x_in > X_MAX) ? X_MAX : x_in;
      end
    end

    assign y_end       = {1'b0, y1} + REW'(OUT_ROWS - 1);
    assign x_end       = {1'b0, x1} + CEW'(OUT_COLS - 1);
    assign hit[k]      = (row >= y1) && ({1'b0, row} <= y_end) &&
                         (col >= x1) && ({1'b0, col} <= x_end);
    assign last_vec[k] = ({1'b0, reg_row} == y_end) && ({1'b0, reg_col} == x_end);
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= LOAD;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (crop_load && last_slot)          state_nxt = STREAM;
      STREAM:  if (pix_acc && last_row && last_col) state_nxt = DRAIN;
      DRAIN:   if (mask == '0)                      state_nxt = LOAD;
      default:                                      state_nxt = LOAD;
    endcase
  end

  // Outputs. A new pixel can only be taken when the held one is gone or is
  // leaving this cycle with its final beat, so overlaps stall the input.
  always_comb begin
    crop_TREADY     = (state == LOAD);
    pixel_in_TREADY = (state == STREAM) && ((mask == '0) || (onehot && pixel_out_TREADY));
    frame_done      = (state == DRAIN) && (mask == '0);
  end

  // Lowest pending crop drives the output beat.
  always_comb begin
    logic found;
    found           = 1'b0;
    low_bit         = '0;
    pixel_out_TID   = '0;
    pixel_out_TLAST = 1'b0;
    for (int k = 0; k < NUM_CROPS; k++) begin
      if (mask[k] && !found) begin
        found           = 1'b1;
        low_bit[k]      = 1'b1;
        pixel_out_TID   = CROP_ID_WIDTH'(k);
        pixel_out_TLAST = last_vec[k];
      end
    end
    pixel_out_TVALID = |mask;
    pixel_out_TDATA  = pix;
  end

  // Datapath: crop slot counter, raster counters, held pixel and pending mask.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crop_cnt <= '0;
      row      <= '0;
      col      <= '0;
      reg_row  <= '0;
      reg_col  <= '0;
      pix      <= '0;
      mask     <= '0;
    end else begin
      if (crop_load)
        crop_cnt <= last_slot ? '0 : crop_cnt + 1'b1;
      if (pix_acc) begin
        pix     <= pixel_in_TDATA;
        reg_row <= row;
        reg_col <= col;
        mask    <= hit;   // replaces any final beat leaving this cycle
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end else if (emit) begin
        mask <= mask & ~low_bit;
      end
    end
  end
endmodule

// File: tb/tb_crop_filter_multi.sv
// Bench for crop_filter_multi on a small image (10x16, 4x5 windows, 3 crops).
// The model derives every expected beat from the clamped origins: the n-th
// beat of crop t is pixel (Y1+n/OC, X1+n%OC) of the frame, TLAST on n==OR*OC-1.
module tb_crop_filter_multi;
  localparam int PW = 16, IR = 10, IC = 16, OR = 4, OC = 5;
  localparam int RW = 10, CLW = 10, NC = 3, IDW = 2;
  localparam int NPIX = IR * IC, NBEAT = OR * OC;

  logic clk = 1'b0, reset_n = 1'b0;
  logic [RW+CLW-1:0] crop_TDATA = '0;
  logic crop_TVALID = 1'b0, crop_TREADY;
  logic [PW-1:0] pixel_in_TDATA = '0;
  logic pixel_in_TVALID = 1'b0, pixel_in_TREADY;
  logic [PW-1:0] pixel_out_TDATA;
  logic [IDW-1:0] pixel_out_TID;
  logic pixel_out_TLAST, pixel_out_TVALID;
  logic pixel_out_TREADY = 1'b0;
  logic frame_done;

  always #5 clk = ~clk;

  crop_filter_multi #(
    .PIXEL_BIT_WIDTH(PW), .IN_ROWS(IR), .IN_COLS(IC), .OUT_ROWS(OR), .OUT_COLS(OC),
    .IMG_ROW_BITWIDTH(RW), .IMG_COL_BITWIDTH(CLW), .NUM_CROPS(NC), .CROP_ID_WIDTH(IDW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .crop_TDATA(crop_TDATA), .crop_TVALID(crop_TVALID), .crop_TREADY(crop_TREADY),
    .pixel_in_TDATA(pixel_in_TDATA), .pixel_in_TVALID(pixel_in_TVALID),
    .pixel_in_TREADY(pixel_in_TREADY),
    .pixel_out_TDATA(pixel_out_TDATA), .pixel_out_TID(pixel_out_TID),
    .pixel_out_TLAST(pixel_out_TLAST), .pixel_out_TVALID(pixel_out_TVALID),
    .pixel_out_TREADY(pixel_out_TREADY), .frame_done(frame_done)
  );

  // Model state (origins/base written by stimulus, the rest by the checker)
  int ey[NC], ex[NC];
  int base = 0;
  int beat_cnt[NC], first_d[NC], last_d[NC];
  int chs = 0, fd_cnt = 0, frame_no = 0, to_req = 0, to_seen = 0;
  int checks = 0, errors = 0;
  logic prev_stall = 1'b0;
  logic [PW-1:0] p_data;
  logic [IDW-1:0] p_tid;
  logic p_last;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process
  always @(negedge clk) begin
    int t, n, r, c;
    if (to_req != to_seen) begin
      chk("frame_timeout", to_req, to_seen);
      to_seen = to_req;
    end
    if (!reset_n) begin
      chk("rst_tvalid", pixel_out_TVALID, 0);
      chk("rst_tdata", pixel_out_TDATA, 0);
      chk("rst_tid", pixel_out_TID, 0);
      chk("rst_tlast", pixel_out_TLAST, 0);
      chk("rst_in_tready", pixel_in_TREADY, 0);
      chk("rst_crop_tready", crop_TREADY, 1);
      chk("rst_frame_done", frame_done, 0);
      prev_stall = 1'b0;
      chs = 0;
      for (int k = 0; k < NC; k++) beat_cnt[k] = 0;
    end else begin
      if (prev_stall)
        chk("stall_hold", {pixel_out_TVALID, pixel_out_TID, pixel_out_TLAST, pixel_out_TDATA},
            {1'b1, p_tid, p_last, p_data});
      if (crop_TVALID && crop_TREADY) chs++;
      if (pixel_out_TVALID && pixel_out_TREADY) begin
        t = int'(pixel_out_TID);
        if (t >= NC) chk("tid_range", t, NC - 1);
        else begin
          n = beat_cnt[t];
          if (n >= NBEAT) chk("extra_beat", n, NBEAT - 1);
          else begin
            r = ey[t] + n / OC;
            c = ex[t] + n % OC;
            chk("beat_data", pixel_out_TDATA, (base + r * IC + c) & 16'hFFFF);
            chk("beat_last", pixel_out_TLAST, (n == NBEAT - 1) ? 1 : 0);
            if (n == 0) first_d[t] = pixel_out_TDATA;
            if (n == NBEAT - 1) last_d[t] = pixel_out_TDATA;
          end
          beat_cnt[t]++;
        end
      end
      prev_stall = pixel_out_TVALID && !pixel_out_TREADY;
      p_data = pixel_out_TDATA;
      p_tid  = pixel_out_TID;
      p_last = pixel_out_TLAST;
      if (frame_done) begin
        for (int k = 0; k < NC; k++) begin
          chk("beats_per_tid", beat_cnt[k], NBEAT);
          beat_cnt[k] = 0;
        end
        chk("crop_handshakes", chs, NC);
        chs = 0;
        // hand-computed pins for the first and last frames
        if (frame_no == 0) begin
          chk("f0_tid0_first", first_d[0], 0);
          chk("f0_tid0_last", last_d[0], 52);
          chk("f0_tid1_last", last_d[1], 52);
          chk("f0_tid2_first", first_d[2], 107);
          chk("f0_tid2_last", last_d[2], 159);
        end
        if (frame_no == 3) begin
          chk("f3_tid1_first", first_d[1], 35);
          chk("f3_tid1_last", last_d[1], 87);
          chk("f3_tid2_first", first_d[2], 107);
        end
        frame_no++;
        fd_cnt++;
      end
    end
  end

  task automatic idle();
    crop_TVALID = 1'b0;
    pixel_in_TVALID = 1'b0;
    pixel_out_TREADY = 1'b1;
  endtask

  // One frame: load 3 origins, stream the image, wait for frame_done.
  // rst_after>0 pulses reset once that many pixels were accepted.
  task automatic run_frame(input int y0, x0, y1, x1, y2, x2, input int b,
                           input bit rnd, input bit hold, input int rst_after);
    int cy[NC], cx[NC];
    int ci = 0, pi = 0, cyc = 0, fd0;
    bit done = 0;
    cy = '{y0, y1, y2};
    cx = '{x0, x1, x2};
    for (int k = 0; k < NC; k++) begin
      ey[k] = (cy[k] > IR - OR) ? IR - OR : cy[k];
      ex[k] = (cx[k] > IC - OC) ? IC - OC : cx[k];
    end
    base = b;
    fd0 = fd_cnt;
    while (!done) begin
      crop_TVALID = (ci < NC) || (hold && pi < NPIX);
      if (ci < NC) crop_TDATA = {RW'(cy[ci]), CLW'(cx[ci])};
      else         crop_TDATA = 20'h5A5A5;
      pixel_in_TVALID  = (ci >= NC) && (pi < NPIX) && (!rnd || $urandom_range(1, 0) == 1);
      pixel_in_TDATA   = PW'(b + pi);
      pixel_out_TREADY = !rnd || ($urandom_range(1, 0) == 1);
      @(negedge clk);
      if (crop_TVALID && crop_TREADY && ci < NC) ci++;
      if (pixel_in_TVALID && pixel_in_TREADY) pi++;
      cyc++;
      if (rst_after > 0 && pi >= rst_after) begin
        @(posedge clk); #1;
        reset_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        done = 1;
      end else if (pi == NPIX && fd_cnt != fd0) begin
        done = 1;
      end else if (cyc > 4000) begin
        to_req++;
        done = 1;
      end
      if (!done) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    idle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    // full rate, two identical windows plus an out-of-range origin that clamps to (6,11)
    run_frame(0, 0, 0, 0, 500, 700, 0, 0, 0, 0);
    // random handshakes, crop_TVALID held high through the stream
    run_frame(3, 7, 6, 11, 2, 2, 1000, 1, 1, 0);
    // back-to-back frame, random handshakes
    run_frame(5, 0, 0, 11, 4, 4, 2000, 1, 0, 0);
    // reset mid-frame, partial frame discarded
    run_frame(1, 1, 1, 1, 1, 1, 3000, 1, 0, 70);
    // clean frame after the reset
    run_frame(0, 0, 2, 3, 6, 11, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
